// File: rtl/sevenseg_wishbone_pkg.sv
// Shared register map, CTRL layout and reset constants for the eight-digit
// seven-segment display peripheral.
package sevenseg_wishbone_pkg;

   localparam logic [31:0] SEVENSEG_VALUE = 32'd0;
   localparam logic [31:0] SEVENSEG_CTRL  = 32'd4;
   localparam int          ADR_SEL_BIT    = 2;

   localparam int          CTRL_EN_LSB    = 0;
   localparam int          CTRL_DP_LSB    = 8;
   localparam int          CTRL_BLANK_BIT = 16;
   localparam logic [31:0] CTRL_RESET     = 32'h0000_00FF;

   typedef enum logic {
      REG_VALUE = SEVENSEG_VALUE[ADR_SEL_BIT],
      REG_CTRL  = SEVENSEG_CTRL[ADR_SEL_BIT]
   } reg_sel_e;

   typedef struct packed {
      logic       blank;
      logic [7:0] dp;
      logic [7:0] en;
   } ctrl_t;

   function automatic ctrl_t to_ctrl(logic [16:0] w);
      ctrl_t c;
      c.en    = w[CTRL_EN_LSB +: 8];
      c.dp    = w[CTRL_DP_LSB +: 8];
      c.blank = w[CTRL_BLANK_BIT];
      return c;
   endfunction

   // Reserved bits read back as zero.
   function automatic logic [31:0] from_ctrl(ctrl_t c);
      logic [31:0] w;
      w = '0;
      w[CTRL_EN_LSB +: 8]  = c.en;
      w[CTRL_DP_LSB +: 8]  = c.dp;
      w[CTRL_BLANK_BIT]    = c.blank;
      return w;
   endfunction

endpackage

// File: rtl/sevenseg_wishbone_if.sv
// Data-bus slave port as seen by the display peripheral: strobe from the
// address decoder, write enable, address, write data and registered read data.
interface sevenseg_wishbone_if;

   logic        STB_I;
   logic        WE_I;
   logic [31:0] ADR_I;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;

   modport master (output STB_I, output WE_I, output ADR_I, output DAT_I, input DAT_O);
   modport slave  (input STB_I, input WE_I, input ADR_I, input DAT_I, output DAT_O);

endinterface

// File: rtl/sevenseg_wishbone_hex7seg.sv
// Combinational hex nibble to active-low {a,b,c,d,e,f,g} glyph decoder,
// shared with the VGA text path.
module hex7seg (
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   always_comb begin
      // NOTE: default assigned first so every path drives seg_n; no latch.
      seg_n = 7'b111_1111;
      unique case (nibble)
         4'h0: seg_n = 7'b000_0001;
         4'h1: seg_n = 7'b100_1111;
         4'h2: seg_n = 7'b001_0010;
         4'h3: seg_n = 7'b000_0110;
         4'h4: seg_n = 7'b100_1100;
         4'h5: seg_n = 7'b010_0100;
         4'h6: seg_n = 7'b010_0000;
         4'h7: seg_n = 7'b000_1111;
         4'h8: seg_n = 7'b000_0000;
         4'h9: seg_n = 7'b000_0100;
         4'hA: seg_n = 7'b000_1000;
         4'hB: seg_n = 7'b110_0000;
         4'hC: seg_n = 7'b011_0001;
         4'hD: seg_n = 7'b100_0010;
         4'hE: seg_n = 7'b011_0000;
         4'hF: seg_n = 7'b011_1000;
         default: seg_n = 7'b111_1111;
      endcase
   end

endmodule

// File: rtl/sevenseg_wishbone.sv
// Memory-mapped eight-digit seven-segment display: VALUE/CTRL registers on the
// data bus and a prescaled scan that drives one active-low digit per slot.
module sevenseg_wishbone
   import sevenseg_wishbone_pkg::*;
#(
   parameter logic [26:0] DIV = 27'd100000
) (
   input  logic               CLK_I,
   input  logic               RST_I,
   sevenseg_wishbone_if.slave bus,
   output logic [7:0]         SEG,
   output logic [7:0]         AN
);

   logic [31:0] value_q;
   ctrl_t       ctrl_q;
   logic [31:0] dat_q;
   logic [26:0] pre_q;
   logic [2:0]  idx_q;

   reg_sel_e    sel;
   logic        wr_en;
   logic        rd_en;
   logic        pre_wrap;
   logic [3:0]  nibble;
   logic [6:0]  glyph;
   logic        lit;
   logic [7:0]  an_d;
   logic [7:0]  seg_d;
   logic        unused_bus_bits;

   assign sel      = reg_sel_e'(bus.ADR_I[ADR_SEL_BIT]);
   assign wr_en    = bus.STB_I & bus.WE_I;
   assign rd_en    = bus.STB_I & ~bus.WE_I;
   assign pre_wrap = (pre_q == DIV - 27'd1);
   assign bus.DAT_O = dat_q;

   assign unused_bus_bits = ^{bus.ADR_I[31:3], bus.ADR_I[1:0], bus.DAT_I[31:17]};

   always_ff @(posedge CLK_I) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (RST_I) begin
         value_q <= '0;
         ctrl_q  <= to_ctrl(CTRL_RESET[16:0]);
         dat_q   <= '0;
      end else begin
         if (wr_en) begin
            unique case (sel)
               REG_VALUE: value_q <= bus.DAT_I;
               REG_CTRL:  ctrl_q  <= to_ctrl(bus.DAT_I[16:0]);
               default:   ;
            endcase
         end
         if (rd_en)
            dat_q <= (sel == REG_CTRL) ? from_ctrl(ctrl_q) : value_q;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         pre_q <= '0;
         idx_q <= '0;
      end else if (pre_wrap) begin
         pre_q <= '0;
         idx_q <= idx_q + 3'd1;
      end else begin
         pre_q <= pre_q + 27'd1;
      end
   end

   assign nibble = value_q[{idx_q, 2'b00} +: 4];
   assign lit    = ctrl_q.en[idx_q] & ~ctrl_q.blank;

   hex7seg u_hex7seg (
      .nibble (nibble),
      .seg_n  (glyph)
   );

   always_comb begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
      if (lit) begin
         an_d[idx_q] = 1'b0;
         seg_d       = {glyph, ~ctrl_q.dp[idx_q]};
      end
   end

   // Registered so AN and SEG switch together, one cycle behind idx and the registers.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         AN  <= 8'hFF;
         SEG <= 8'hFF;
      end else begin
         AN  <= an_d;
         SEG <= seg_d;
      end
   end

endmodule

// File: doc/sevenseg_wishbone.md
# sevenseg_wishbone

Memory-mapped eight-digit seven-segment display peripheral on the CPU data bus, a sibling of `ram_wishbone` and `led_wishbone`. It is selected by the top-level address decoder through `STB_I`. It holds a 32-bit hex value and a control word, and time-multiplexes the eight active-low common-anode digits of the board display from a prescaled scan counter.

## Interface
- `DIV`, 27'd100000: system clocks per digit slot; 1 kHz digit rate at 100 MHz. Legal range 2..2^27-1.
- `CLK_I` input 1: system clock.
- `RST_I` input 1: synchronous, active-high reset.
- `STB_I` input 1: peripheral select from the top-level address decoder.
- `WE_I` input 1: write enable; qualified by `STB_I`.
- `ADR_I` input 32: byte address; only bit 2 is decoded.
- `DAT_I` input 32: write data.
- `DAT_O` output 32: registered read data.
- `SEG` output 8: cathodes `{CA,CB,CC,CD,CE,CF,CG,DP}`, active low.
- `AN` output 8: digit anodes, active low; `AN[0]` is the rightmost digit.

## Operation
- Register map, selected by `ADR_I[2]`:
  - 0 = `VALUE[31:0]`, read/write. Digit i shows nibble `VALUE[4i+3:4i]`.
  - 1 = `CTRL`, read/write:
    - `[7:0]` digit enable mask.
    - `[15:8]` decimal-point mask.
    - `[16]` blank.
    - `[31:17]` reserved: writes ignored, reads 0.
- Write: on a rising edge with `STB_I & WE_I`, the selected register loads `DAT_I`. There is no byte enables and no ACK; every strobe completes in one cycle.
- Read: every edge with `STB_I & ~WE_I` loads `DAT_O` with the selected register. `DAT_O` holds its value otherwise.
- Prescaler `pre` (27 bit) counts 0..DIV-1. On the terminal count it wraps to 0 and digit index `idx` (3 bit) increments, wrapping 7 -> 0.
- Display output register, updated every cycle from the current `idx`:
  - `AN` = all ones except bit `idx`, which is 0 only if `CTRL[idx] & ~CTRL[16]`.
  - `SEG[7:1]` = active-low hex glyph of the selected nibble (0-9, A, b, C, d, E, F).
  - `SEG[0]` = `~CTRL[8+idx]`.
  - When the digit is disabled or blanked, `SEG` = 8'hFF.
- Reset values:
  - `VALUE` = 0.
  - `CTRL` = 32'h000000FF.
  - `DAT_O` = 0.
  - `pre` = 0, `idx` = 0.
  - `SEG` = 8'hFF, `AN` = 8'hFF.
- Simultaneous write and scan step: the display uses the pre-write register value in that cycle and the new value from the next cycle.

## Timing
- Write-to-display latency: 1 cycle after the write edge, for the currently scanned digit.
- Read latency: `DAT_O` is valid 1 cycle after the strobed edge.
- Digit period is exactly `DIV` cycles; a full frame is `8*DIV` cycles.
- `idx` changes on the edge where `pre == DIV-1`; `AN`/`SEG` follow 1 cycle later.
- Reset mid-scan: `idx` and `pre` return to 0 on that edge. Outputs are 8'hFF during reset and for the first cycle after it, then digit 0 is driven.
- No glitch requirement between digits. Outputs are registered, so `AN` and `SEG` change on the same edge.

## Structure
- A shared package/header holds:
  - register offsets `SEVENSEG_VALUE = 0` and `SEVENSEG_CTRL = 4`;
  - `CTRL` field positions;
  - the `CTRL` reset constant 32'h000000FF.
- Sub-module `hex7seg`: purely combinational 4-bit nibble to 7-bit active-low `{a..g}` decoder. It is also reusable by the VGA text path.
- Top level instantiates this block beside `ram_wishbone`, with its own decoder strobe.

## Test plan
- Reset: hold `RST_I` for 3 cycles -> `SEG` = 8'hFF, `AN` = 8'hFF, `DAT_O` = 0; reads give `VALUE` = 0 and `CTRL` = 32'h000000FF.
- Write/read: with `DIV` = 4, write `VALUE` = 32'h89ABCDEF, then read `ADR_I` = 0 -> `DAT_O` = 32'h89ABCDEF one cycle later. Write `CTRL` = 32'hFFFF_FFFF -> readback 32'h0001FFFF.
- Scan: with `DIV` = 4, `VALUE` = 32'h76543210 and `CTRL` = 32'hFF:
  - `AN` steps FE, FD, FB, ... 7F, FE, with each value held for exactly 4 cycles;
  - digit 0 gives `SEG` = 8'b0000_0011;
  - digit 7 gives `SEG` = 8'b0001_1111.
- Masks: `CTRL` = 32'h0000_0205 -> only `AN` = FE and FB ever go low; `SEG[0]` is 0 never (digit 1 is disabled).
- Blank: set `CTRL[16]` mid-frame -> `AN` = 8'hFF and `SEG` = 8'hFF from the next cycle on. Clearing it resumes at the current `idx`.
- Reset mid-scan: assert `RST_I` while `idx` = 5 -> after release, first active `AN` = FE and the prescaler restarts, giving a full `DIV`-cycle slot.
